// File: rtl/camkey_loader.sv
// Serial key loader for the camouflaged c432 core: shifts in a key frame,
// verifies its nibble checksum and only then drives the camouflage selects.
module camkey_loader #(
    parameter int KEY_W    = 12,
    parameter int CHK_W    = 4,
    parameter int ONE_TIME = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             key_bit,
    input  logic             key_valid,
    output logic             key_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_locked,
    output logic             key_err,
    output logic             busy
);

    localparam int FRAME_W = KEY_W + CHK_W;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int SLICES  = KEY_W / CHK_W;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        LOCKED,
        ERROR
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] staging;
    logic [CHK_W-1:0]   key_sum;
    logic               chk_ok;

    // The frame arrives LSB first, so after a full frame staging[0] holds key[0]
    // and the check field occupies the top CHK_W bits.
    always_comb begin
        key_sum = '0;
        for (int i = 0; i < SLICES; i++) begin
            key_sum = key_sum ^ staging[i*CHK_W +: CHK_W];
        end
        chk_ok = (key_sum == staging[FRAME_W-1 -: CHK_W]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            staging    <= '0;
            key_out    <= '0;
            key_locked <= 1'b0;
            key_err    <= 1'b0;
            key_ready  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SHIFT;
                        bit_cnt   <= '0;
                        key_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (key_valid) begin
                        staging <= {key_bit, staging[FRAME_W-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            state     <= CHECK;
                            key_ready <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    busy <= 1'b0;
                    if (chk_ok) begin
                        state      <= LOCKED;
                        key_out    <= staging[KEY_W-1:0];
                        key_locked <= 1'b1;
                        key_err    <= 1'b0;
                    end else begin
                        state <= ERROR;
                        key_err <= 1'b1;
                    end
                end
                LOCKED: begin
                    // key_out is deliberately left alone; it only moves on a passing CHECK.
                    if (ONE_TIME == 0 && start) begin
                        state      <= SHIFT;
                        bit_cnt    <= '0;
                        key_locked <= 1'b0;
                        key_ready  <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ERROR: begin
                    if (start) begin
                        state     <= SHIFT;
                        bit_cnt   <= '0;
                        key_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/camkey_loader.md
# camkey_loader

Serial key loader sitting directly upstream of the camouflaged c432 core. It receives a key frame one bit per handshake, verifies a nibble checksum, and only then drives the core's camouflage select inputs s_0..s_11. The core is enabled only after a verified key is latched, and the select bus never changes while the core is enabled.

## Interface
- KEY_W, 12: key bits; one pair per camouflaged gate. Must be even and a multiple of CHK_W.
- CHK_W, 4: checksum width. Checksum is the XOR of all CHK_W-bit slices of the key.
- ONE_TIME, 1: 1 = LOCKED is terminal until reset; 0 = start re-arms loading from LOCKED.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level-sampled request to begin a frame.
- key_bit  in  1  serial frame data.
- key_valid  in  1  key_bit is valid this cycle.
- key_ready  out  1  loader accepts a bit this cycle.
- key_out  out  KEY_W  drives s_0..s_(KEY_W-1); bit i -> s_i.
- key_locked  out  1  verified key is on key_out; core enable.
- key_err  out  1  last frame failed its checksum.
- busy  out  1  state is SHIFT or CHECK.

## Operation
- Frame: KEY_W key bits, then CHK_W check bits. Each field is sent LSB first. The first accepted bit is key[0].
- Data is accepted only on key_valid & key_ready. key_bit is ignored when key_valid=0.
- An internal bit counter runs 0..KEY_W+CHK_W-1, with width clog2(KEY_W+CHK_W). Bits go into a staging shift register, not into key_out.
- IDLE: key_ready=0. start=1 -> SHIFT, counter cleared.
- SHIFT: key_ready=1; start is ignored. On the accepted bit with counter = KEY_W+CHK_W-1 -> CHECK.
- CHECK: key_ready=0 for one cycle. The loader compares the XOR of the staged key slices with the staged check field.
  - Match -> LOCKED. key_out is loaded from staging and key_err is cleared on that edge.
  - Mismatch -> ERROR. key_out keeps its prior value.
- LOCKED: key_locked=1.
  - ONE_TIME=1: start is ignored.
  - ONE_TIME=0: start -> SHIFT. key_locked drops on that edge; key_out holds its old value until a new frame passes CHECK.
- ERROR: key_err=1, key_locked=0. start -> SHIFT with key_err held at 1 until the next successful CHECK.
- Rule: key_out changes only on a CHECK->LOCKED edge or on reset.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE, counter 0, staging 0.
  - key_out 0, key_locked 0, key_err 0, key_ready 0, busy 0.
- start sampled in IDLE -> key_ready=1 the next cycle.
- Minimum latency from the start cycle to key_locked=1 is KEY_W+CHK_W+2 cycles (18 with the defaults): 1 cycle to enter SHIFT, 16 accepted bits, 1 CHECK cycle, with key_locked visible after the CHECK edge.
- Stalls (key_valid=0) extend SHIFT indefinitely. There is no timeout.
- Reset asserted mid-frame aborts the frame. Partial staging is never applied, and all outputs return to their reset values.
- key_valid during CHECK, IDLE, LOCKED or ERROR is not accepted (key_ready=0). Those bits are lost, not queued.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Good key: reset, start, send key 12'hA5C then chk 4'h3 (C^5^A), no stalls -> key_locked=1 in cycle 18, key_out=12'hA5C, key_err=0.
- Bad checksum: send 12'hA5C with chk 4'h2 -> key_err=1, key_locked=0, key_out=0. Then resend the good frame -> key_locked=1, key_err=0, key_out=12'hA5C.
- Stalls: drop key_valid randomly for about 50% of cycles during the 12'hFFF/chk 4'hF frame -> key_locked=1 and key_out=12'hFFF. No bit is accepted while key_valid=0.
- Mid-frame reset: assert rst after 7 accepted bits -> all outputs 0 immediately. Start again with a full 12'h123/chk 4'h0 frame -> key_out=12'h123.
- ONE_TIME=1: after lock at 12'hA5C, pulse start and drive a new frame -> key_ready stays 0 and key_out stays 12'hA5C.
- ONE_TIME=0: same stimulus with 12'h0F0/chk 4'hF -> key_locked=0 during the reload, key_out=12'hA5C until CHECK, then key_out=12'h0F0 and key_locked=1.
